event_uart_bridge: RTL

- Collects user-input events from the board and queues them as bytes for the UART transmitter.
- Sources: NUM_BTN push buttons, debounced internally, and 8-bit IR commands from the IR receiver.
- Buffers events in a FIFO of FIFO_DEPTH bytes and drives the UART tx data/load handshake.
- Sits between the buttons/ir_receiver paths and uart_usb in the top level. It replaces the fixed 4-button, unbuffered path with a parametrised, lossless-until-full one.

---
 rtl/event_uart_bridge.sv | 265 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/event_uart_bridge.sv
// Event collector: debounced buttons and IR commands are encoded as bytes, queued and fed to a UART.
// Optional release events are enabled by defining EVENT_UART_BRIDGE_RELEASE_EN.
module event_uart_bridge #(
  parameter int NUM_BTN         = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int FIFO_DEPTH      = 16,
  parameter int FIFO_AW         = 4
) (
  input  logic               clk_50,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] buttons_num,
  input  logic [7:0]         ir_cmd,
  input  logic               ir_cmd_ready,
  input  logic               tx_busy,
  output logic [7:0]         tx_data,
  output logic               tx_load,
  output logic [NUM_BTN-1:0] btn_state,
  output logic [FIFO_AW:0]   fifo_count,
  output logic               overflow,
  output logic               wr_fsm_state,
  output logic [1:0]         tx_fsm_state
);

  localparam int DB_W  = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int CNT_W = FIFO_AW + 1;
  localparam logic [DB_W-1:0]  DB_MAX   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_IR   = CNT_W'(FIFO_DEPTH - 2);

  typedef enum logic {W_IDLE, W_IR2} wr_state_t;
  typedef enum logic [1:0] {T_IDLE, T_LOAD, T_WAITH, T_WAITL} tx_state_t;

  wr_state_t wr_state, wr_next;
  tx_state_t tx_state, tx_next;

  logic [NUM_BTN-1:0]            sync_q1, sync_q2, pressed_lvl;
  logic [NUM_BTN-1:0][DB_W-1:0]  db_cnt;
  logic [NUM_BTN-1:0]            btn_rise, btn_pend, btn_clr, btn_onehot;
  logic [3:0]                    btn_sel;
  logic                          btn_any;
  logic                          ir_pend, ir_clr;
  logic [7:0]                    ir_reg;
  logic                          wr_en, rd_en, drop_evt;
  logic [7:0]                    wr_byte;
  logic                          ir_room, any_room, fifo_nempty;
  logic [7:0]                    mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0]            wr_ptr, rd_ptr;
  logic [1:0]                    wait_cnt;

  assign wr_fsm_state = wr_state;
  assign tx_fsm_state = tx_state;

  // Raw buttons idle high; synchronisers reset to the released level so reset creates no event.
  always_ff @(posedge clk_50 or negedge reset) begin
    if (!reset) begin
      sync_q1 <= '1;
      sync_q2 <= '1;
    end else begin
      sync_q1 <= buttons_num;
      sync_q2 <= sync_q1;
    end
  end

  assign pressed_lvl = ~sync_q2;

  always_comb begin
    btn_rise = '0;
    for (int i = 0; i < NUM_BTN; i++)
      btn_rise[i] = (pressed_lvl[i] != btn_state[i]) && (db_cnt[i] == DB_MAX) && !btn_state[i];
  end

  always_ff @(posedge clk_50 or negedge reset) begin
    if (!reset) begin
      btn_state <= '0;
      db_cnt    <= '0;
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        if (pressed_lvl[i] == btn_state[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_MAX) begin
          db_cnt[i]    <= '0;
          btn_state[i] <= ~btn_state[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    btn_sel    = '0;
    btn_any    = 1'b0;
    btn_onehot = '0;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (btn_pend[i]) begin
        btn_sel       = 4'(i);
        btn_any       = 1'b1;
        btn_onehot    = '0;
        btn_onehot[i] = 1'b1;
      end
    end
  end

`ifdef EVENT_UART_BRIDGE_RELEASE_EN
  logic [NUM_BTN-1:0] btn_fall, rel_pend, rel_clr, rel_onehot;
  logic [3:0]         rel_sel;
  logic               rel_any;

  always_comb begin
    btn_fall = '0;
    for (int i = 0; i < NUM_BTN; i++)
      btn_fall[i] = (pressed_lvl[i] != btn_state[i]) && (db_cnt[i] == DB_MAX) && btn_state[i];
  end

  always_comb begin
    rel_sel    = '0;
    rel_any    = 1'b0;
    rel_onehot = '0;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (rel_pend[i]) begin
        rel_sel       = 4'(i);
        rel_any       = 1'b1;
        rel_onehot    = '0;
        rel_onehot[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_50 or negedge reset) begin
    if (!reset) rel_pend <= '0;
    else        rel_pend <= (rel_pend & ~rel_clr) | (btn_fall & ~rel_pend);
  end

  assign drop_evt = (ir_cmd_ready & ir_pend) | (|(btn_rise & btn_pend)) | (|(btn_fall & rel_pend));
`else
  assign drop_evt = (ir_cmd_ready & ir_pend) | (|(btn_rise & btn_pend));
`endif

  // A flag that is set drops any new edge, even in the cycle it is being consumed.
  always_ff @(posedge clk_50 or negedge reset) begin
    if (!reset) begin
      btn_pend <= '0;
      ir_pend  <= 1'b0;
      ir_reg   <= '0;
      overflow <= 1'b0;
    end else begin
      btn_pend <= (btn_pend & ~btn_clr) | (btn_rise & ~btn_pend);
      if (ir_cmd_ready && !ir_pend) begin
        ir_reg  <= ir_cmd;
        ir_pend <= 1'b1;
      end else if (ir_clr) begin
        ir_pend <= 1'b0;
      end
      if (drop_evt) overflow <= 1'b1;
    end
  end

  assign ir_room     = (fifo_count <= CNT_IR);
  assign any_room    = (fifo_count != CNT_FULL);
  assign fifo_nempty = (fifo_count != '0);

  always_ff @(posedge clk_50 or negedge reset) begin
    if (!reset) wr_state <= W_IDLE;
    else        wr_state <= wr_next;
  end

  always_comb begin
    wr_next = wr_state;
    case (wr_state)
      W_IDLE:  if (ir_pend && ir_room) wr_next = W_IR2;
      W_IR2:   wr_next = W_IDLE;
      default: wr_next = W_IDLE;
    endcase
  end

  // IR header is only written with two free slots so the second byte always fits.
  always_comb begin
    wr_en   = 1'b0;
    wr_byte = '0;
    btn_clr = '0;
    ir_clr  = 1'b0;
`ifdef EVENT_UART_BRIDGE_RELEASE_EN
    rel_clr = '0;
`endif
    case (wr_state)
      W_IDLE: begin
        if (ir_pend && ir_room) begin
          wr_en   = 1'b1;
          wr_byte = 8'hC1;
        end else if (btn_any && any_room) begin
          wr_en   = 1'b1;
          wr_byte = {4'hA, btn_sel};
          btn_clr = btn_onehot;
`ifdef EVENT_UART_BRIDGE_RELEASE_EN
        end else if (rel_any && any_room) begin
          wr_en   = 1'b1;
          wr_byte = {4'hB, rel_sel};
          rel_clr = rel_onehot;
`endif
        end
      end
      W_IR2: begin
        wr_en   = 1'b1;
        wr_byte = ir_reg;
        ir_clr  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_50) begin
    if (wr_en) mem[wr_ptr] <= wr_byte;
  end

  always_ff @(posedge clk_50 or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // UART handshake: a byte is offered by a one-cycle tx_load only while tx_busy=0; tx_busy=1
  // means the UART owns tx_data, which stays unchanged until tx_busy falls.
  always_ff @(posedge clk_50 or negedge reset) begin
    if (!reset) tx_state <= T_IDLE;
    else        tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      T_IDLE:  if (fifo_nempty && !tx_busy) tx_next = T_LOAD;
      T_LOAD:  tx_next = T_WAITH;
      T_WAITH: if (tx_busy || wait_cnt == 2'd3) tx_next = T_WAITL;
      T_WAITL: if (!tx_busy) tx_next = T_IDLE;
      default: tx_next = T_IDLE;
    endcase
  end

  always_comb begin
    rd_en   = (tx_state == T_IDLE) && fifo_nempty && !tx_busy;
    tx_load = (tx_state == T_LOAD);
  end

  // A UART that never raises busy is released after four cycles in T_WAITH.
  always_ff @(posedge clk_50 or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
      tx_data  <= '0;
    end else begin
      wait_cnt <= (tx_state == T_WAITH) ? wait_cnt + 1'b1 : 2'd0;
      if (rd_en) tx_data <= mem[rd_ptr];
    end
  end

endmodule
